// File: rtl/stopwatch_pkg.sv
// rtl/stopwatch_pkg.sv - shared state encoding, time record and increment helper
package stopwatch_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam logic [6:0] MS10_MAX = 7'd99;
    localparam logic [5:0] SEC_MAX  = 6'd59;

    typedef struct packed {
        logic [5:0] min;
        logic [5:0] sec;
        logic [6:0] ms_10;
    } time_t;

    localparam int TIME_W = $bits(time_t);

    // Ripple-carry one hundredth; the caller guards the saturation point.
    function automatic time_t time_inc(input time_t t);
        time_t r;
        r = t;
        if (t.ms_10 != MS10_MAX) begin
            r.ms_10 = t.ms_10 + 7'd1;
        end else begin
            r.ms_10 = '0;
            if (t.sec != SEC_MAX) begin
                r.sec = t.sec + 6'd1;
            end else begin
                r.sec = '0;
                r.min = t.min + 6'd1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/stopwatch_lap_mem.sv
// rtl/stopwatch_lap_mem.sv - lap record array with write pointer and valid count
module stopwatch_lap_mem
    import stopwatch_pkg::*;
#(
    parameter int LAP_DEPTH = 8,
    localparam int AW = $clog2(LAP_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en_i,
    input  logic              clr_i,
    input  logic [TIME_W-1:0] wr_data_i,
    input  logic [AW-1:0]     rd_idx_i,
    output logic [TIME_W-1:0] rd_data_o,
    output logic [AW:0]       count_o,
    output logic              full_o
);

    logic [TIME_W-1:0] mem_q [LAP_DEPTH];
    logic [AW:0]       count_q, count_d;
    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic              do_write;

    assign full_o   = (count_q == (AW+1)'(LAP_DEPTH));
    assign do_write = wr_en_i && !full_o && !clr_i && !rst;

    always_comb begin
        count_d  = count_q;
        wr_ptr_d = wr_ptr_q;
        if (clr_i) begin
            count_d  = '0;
            wr_ptr_d = '0;
        end else if (do_write) begin
            count_d  = count_q + 1'b1;
            wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q  <= '0;
            wr_ptr_q <= '0;
        end else begin
            count_q  <= count_d;
            wr_ptr_q <= wr_ptr_d;
        end
    end

    // Record contents survive reset; only the count decides validity.
    always_ff @(posedge clk) begin
        if (do_write) begin
            mem_q[wr_ptr_q] <= wr_data_i;
        end
    end

    assign rd_data_o = mem_q[rd_idx_i];
    assign count_o   = count_q;

endmodule

// File: rtl/stopwatch_lap_ctrl.sv
// rtl/stopwatch_lap_ctrl.sv - run/pause FSM, tick prescaler, min:sec:10ms counter and display mux
module stopwatch_lap_ctrl
    import stopwatch_pkg::*;
#(
    parameter int TICK_DIV  = 500000,
    parameter int LAP_DEPTH = 8,
    parameter int MIN_MAX   = 59,
    localparam int AW = $clog2(LAP_DEPTH),
    localparam int PW = $clog2(TICK_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start_stop,
    input  logic          lap,
    input  logic          view_lap,
    input  logic [AW-1:0] lap_idx,
    output logic [5:0]    min_o,
    output logic [5:0]    sec_o,
    output logic [6:0]    ms_10_o,
    output logic          running,
    output logic [AW:0]   lap_count,
    output logic          lap_full,
    output logic          overflow
);

    state_t            state_q;
    logic [PW-1:0]     presc_q;
    time_t             time_q;
    logic              overflow_q;
    logic [TIME_W-1:0] disp_q, disp_d;

    logic              lp, tick, at_max;
    logic              lap_wr, lap_clr, show_lap;
    logic [TIME_W-1:0] lap_rd;
    logic [AW:0]       lap_cnt;

    // start_stop has priority over a coincident lap press.
    assign lp     = lap && !start_stop;
    assign tick   = (state_q == RUN) && (presc_q == PW'(TICK_DIV - 1));
    assign at_max = (time_q.min == 6'(MIN_MAX)) && (time_q.sec == SEC_MAX)
                    && (time_q.ms_10 == MS10_MAX);

    assign lap_wr  = lp && (state_q == RUN);
    assign lap_clr = lp && (state_q != RUN);

    stopwatch_lap_mem #(
        .LAP_DEPTH (LAP_DEPTH)
    ) u_lap_mem (
        .clk       (clk),
        .rst       (rst),
        .wr_en_i   (lap_wr),
        .clr_i     (lap_clr),
        .wr_data_i (time_q),
        .rd_idx_i  (lap_idx),
        .rd_data_o (lap_rd),
        .count_o   (lap_cnt),
        .full_o    (lap_full)
    );

    assign show_lap = view_lap && ({1'b0, lap_idx} < lap_cnt);

    always_comb begin
        disp_d = time_q;
        if (show_lap) begin
            disp_d = lap_rd;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            presc_q    <= '0;
            time_q     <= '0;
            overflow_q <= 1'b0;
            disp_q     <= '0;
        end else begin
            disp_q <= disp_d;
            unique case (state_q)
                IDLE: begin
                    if (start_stop) begin
                        state_q <= RUN;
                    end else if (lp) begin
                        overflow_q <= 1'b0;
                    end
                end
                RUN: begin
                    presc_q <= tick ? '0 : presc_q + 1'b1;
                    if (tick) begin
                        if (at_max) begin
                            overflow_q <= 1'b1;
                            state_q    <= PAUSE;
                        end else begin
                            time_q <= time_inc(time_q);
                        end
                    end
                    if (start_stop) begin
                        state_q <= PAUSE;
                    end
                end
                PAUSE: begin
                    // After saturation only a clear leaves PAUSE.
                    if (start_stop && !overflow_q) begin
                        state_q <= RUN;
                    end else if (lp) begin
                        state_q    <= IDLE;
                        presc_q    <= '0;
                        time_q     <= '0;
                        overflow_q <= 1'b0;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign {min_o, sec_o, ms_10_o} = disp_q;
    assign running   = (state_q == RUN);
    assign lap_count = lap_cnt;
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_stopwatch_lap_ctrl.sv
// tb/tb_stopwatch_lap_ctrl.sv - reference-model bench for stopwatch_lap_ctrl
module tb_stopwatch_lap_ctrl;

    localparam int TICK_DIV  = 4;
    localparam int LAP_DEPTH = 4;
    localparam int MIN_MAX   = 1;
    localparam int MAX_CS    = (MIN_MAX * 60 + 59) * 100 + 99;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start_stop = 1'b0;
    logic       lap = 1'b0;
    logic       view_lap = 1'b0;
    logic [1:0] lap_idx = 2'd0;
    logic [5:0] min_o, sec_o;
    logic [6:0] ms_10_o;
    logic       running;
    logic [2:0] lap_count;
    logic       lap_full, overflow;

    always #5 clk = ~clk;

    stopwatch_lap_ctrl #(
        .TICK_DIV  (TICK_DIV),
        .LAP_DEPTH (LAP_DEPTH),
        .MIN_MAX   (MIN_MAX)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .start_stop (start_stop),
        .lap        (lap),
        .view_lap   (view_lap),
        .lap_idx    (lap_idx),
        .min_o      (min_o),
        .sec_o      (sec_o),
        .ms_10_o    (ms_10_o),
        .running    (running),
        .lap_count  (lap_count),
        .lap_full   (lap_full),
        .overflow   (overflow)
    );

    int n_chk = 0;
    int n_fail = 0;

    // Time is held as total hundredths; state 0=idle 1=run 2=pause.
    int m_state = 0, m_cyc = 0, m_cs = 0, m_disp = 0;
    bit m_ovf = 1'b0, m_valid = 1'b0;
    int laps[$];

    always @(posedge clk) begin
        bit tick, lp;
        if (rst) begin
            m_state = 0; m_cyc = 0; m_cs = 0; m_disp = 0; m_ovf = 1'b0;
            laps.delete();
            m_valid = 1'b1;
        end else begin
            m_disp = (view_lap && (int'(lap_idx) < laps.size())) ? laps[lap_idx] : m_cs;
            tick = (m_state == 1) && (m_cyc == TICK_DIV - 1);
            lp   = lap && !start_stop;
            case (m_state)
                0: begin
                    if (start_stop) m_state = 1;
                    else if (lp) begin laps.delete(); m_ovf = 1'b0; end
                end
                1: begin
                    if (lp && laps.size() < LAP_DEPTH) laps.push_back(m_cs);
                    m_cyc = tick ? 0 : m_cyc + 1;
                    if (tick) begin
                        if (m_cs == MAX_CS) begin m_ovf = 1'b1; m_state = 2; end
                        else m_cs = m_cs + 1;
                    end
                    if (start_stop) m_state = 2;
                end
                default: begin
                    if (start_stop && !m_ovf) m_state = 1;
                    else if (lp) begin
                        m_state = 0; m_cs = 0; m_cyc = 0; m_ovf = 1'b0;
                        laps.delete();
                    end
                end
            endcase
        end
    end

    always @(negedge clk) begin
        if (m_valid) begin
            n_chk++;
            if ({min_o, sec_o, ms_10_o, running, lap_count, lap_full, overflow} !==
                {6'(m_disp / 6000), 6'((m_disp / 100) % 60), 7'(m_disp % 100),
                 (m_state == 1), 3'(laps.size()), (laps.size() == LAP_DEPTH), m_ovf}) begin
                n_fail++;
                $display("FAIL model_cmp t=%0t got %0d:%0d:%0d run=%0b cnt=%0d full=%0b ovf=%0b expected %0d:%0d:%0d run=%0b cnt=%0d full=%0b ovf=%0b",
                         $time, min_o, sec_o, ms_10_o, running, lap_count, lap_full, overflow,
                         m_disp / 6000, (m_disp / 100) % 60, m_disp % 100,
                         (m_state == 1), laps.size(), (laps.size() == LAP_DEPTH), m_ovf);
            end
        end
    end

    task automatic check(input string name, input int act, input int exp);
        n_chk++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic check_time(input string name, input int m, input int s, input int c);
        check({name, "_min"}, min_o, m);
        check({name, "_sec"}, sec_o, s);
        check({name, "_ms10"}, ms_10_o, c);
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #2;
        end
    endtask

    task automatic pulse(input bit s, input bit l);
        start_stop = s;
        lap = l;
        step(1);
        start_stop = 1'b0;
        lap = 1'b0;
    endtask

    task automatic wait_cs(input int target);
        int k;
        k = 0;
        while (m_cs != target && k < 60000) begin
            step(1);
            k++;
        end
        check("wait_cs_reached", m_cs, target);
    endtask

    task automatic restart();
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b0);
    endtask

    initial begin
        step(2);
        rst = 1'b0;
        check_time("reset", 0, 0, 0);
        check("reset_running", running, 0);
        check("reset_count", lap_count, 0);
        check("reset_overflow", overflow, 0);

        pulse(1'b1, 1'b0);
        step(4);
        check("pre_first_tick", ms_10_o, 0);
        step(1);
        check("first_tick", ms_10_o, 1);
        step(396);
        check_time("one_second", 0, 1, 0);
        check("one_second_running", running, 1);

        restart();
        wait_cs(5);
        pulse(1'b1, 1'b0);
        step(50);
        check_time("paused", 0, 0, 5);
        check("paused_running", running, 0);
        pulse(1'b1, 1'b0);
        step(3);
        check("resume_held", ms_10_o, 5);
        step(1);
        check("resume_tick", ms_10_o, 6);

        restart();
        wait_cs(3);  pulse(1'b0, 1'b1);
        wait_cs(7);  pulse(1'b0, 1'b1);
        wait_cs(12); pulse(1'b0, 1'b1);
        wait_cs(20); pulse(1'b0, 1'b1);
        check("laps_count4", lap_count, 4);
        check("laps_full", lap_full, 1);
        wait_cs(25); pulse(1'b0, 1'b1);
        check("lap_ignored_when_full", lap_count, 4);
        view_lap = 1'b1;
        lap_idx = 2'd2; step(1);
        check_time("view_idx2", 0, 0, 12);
        lap_idx = 2'd0; step(1);
        check_time("view_idx0", 0, 0, 3);
        lap_idx = 2'd3; step(1);
        check_time("view_idx3", 0, 0, 20);
        pulse(1'b1, 1'b0);
        pulse(1'b0, 1'b1);
        check("clear_count", lap_count, 0);
        pulse(1'b1, 1'b0);
        wait_cs(10);
        step(1);
        check_time("view_beyond_count", 0, 0, 10);
        view_lap = 1'b0;

        pulse(1'b0, 1'b1);
        pulse(1'b1, 1'b1);
        check("ss_lap_running", running, 0);
        check("ss_lap_count", lap_count, 1);
        pulse(1'b1, 1'b0);

        restart();
        wait_cs(9);
        step(TICK_DIV - 1);
        pulse(1'b0, 1'b1);
        check("coinc_count", lap_count, 1);
        view_lap = 1'b1; lap_idx = 2'd0; step(1);
        check_time("coinc_stored", 0, 0, 9);
        view_lap = 1'b0; step(1);
        check("coinc_live", ms_10_o, 10);

        restart();
        wait_cs(MAX_CS);
        step(TICK_DIV);
        check("ovf_set", overflow, 1);
        check("ovf_running", running, 0);
        step(1);
        check_time("ovf_held", 1, 59, 99);
        pulse(1'b1, 1'b0);
        check("ovf_ss_ignored", running, 0);
        step(2);
        check_time("ovf_still_held", 1, 59, 99);
        pulse(1'b0, 1'b1);
        step(1);
        check_time("ovf_cleared", 0, 0, 0);
        check("ovf_cleared_flag", overflow, 0);

        pulse(1'b1, 1'b0);
        wait_cs(2); pulse(1'b0, 1'b1);
        wait_cs(4); pulse(1'b0, 1'b1);
        check("rst_pre_count", lap_count, 2);
        rst = 1'b1; step(1); rst = 1'b0;
        check_time("rst_mid", 0, 0, 0);
        check("rst_mid_running", running, 0);
        check("rst_mid_count", lap_count, 0);
        check("rst_mid_full", lap_full, 0);
        check("rst_mid_overflow", overflow, 0);

        for (int i = 0; i < 4000; i++) begin
            start_stop = ($urandom % 16 == 0);
            lap        = ($urandom % 10 == 0);
            if ($urandom % 8 == 0) view_lap = $urandom % 2;
            lap_idx    = 2'($urandom);
            rst        = ($urandom % 800 == 0);
            step(1);
        end
        start_stop = 1'b0; lap = 1'b0; rst = 1'b0;
        step(2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
